// File: rtl/led_frame_sched.sv
// Frame scheduler for the LED driver: periodic start pulses, busy handshake, end-of-frame pulse,
// per-frame frozen colour vector and a zone pattern that rotates every ROTATE_FRAMES frames.
module led_frame_sched #(
    parameter int ZONES         = 8,
    parameter int CW            = 4,
    parameter int FRAME_PERIOD  = 2070000,
    parameter int ROTATE_FRAMES = 64,
    parameter int ACK_TIMEOUT   = 16,
    parameter logic [ZONES*3*CW-1:0] PAT_RST = 96'hfff_f0f_00f_0ff_0f0_ff0_fa0_f00
) (
    input  logic                    clk_fast,
    input  logic                    rstn,
    input  logic                    run_i,
    input  logic                    busy_i,
    input  logic                    load_i,
    input  logic [ZONES*3*CW-1:0]   pattern_i,
    input  logic                    clr_i,
    output logic                    start_o,
    output logic                    en_o,
    output logic [ZONES*3*CW-1:0]   color_o,
    output logic [15:0]             frame_cnt_o,
    output logic                    overrun_o,
    output logic                    ack_err_o,
    output logic [2:0]              dbg_state_o
);

    localparam int PW = ZONES * 3 * CW;
    localparam int ZW = 3 * CW;
    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(ROTATE_FRAMES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_PERIOD - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] ROT_LAST  = RW'(ROTATE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_ISSUE     = 3'd2,
        S_ACK       = 3'd3,
        S_DONE      = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [AW-1:0]   r_ack_cnt;
    logic [RW-1:0]   r_rot_cnt;
    logic [PW-1:0]   r_pat;
    logic [PW-1:0]   r_color;
    logic [15:0]     r_frame_cnt;
    logic            r_start;
    logic            r_en;
    logic            r_overrun;
    logic            r_ack_err;
    logic            w_tick;

    assign w_tick = run_i && (r_tick_cnt == TICK_LAST);

    // Free-running period counter; parked at zero whenever scheduling is disabled.
    always_ff @(posedge clk_fast) begin
        if (!rstn) begin
            r_tick_cnt <= '0;
        end else if (!run_i || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_en        <= 1'b0;
            r_color     <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_ack_err   <= 1'b0;
            r_pat       <= PAT_RST;
            r_rot_cnt   <= '0;
            r_ack_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            r_en    <= 1'b0;
            // Clear first so a flag raised below in the same cycle survives.
            if (clr_i) begin
                r_overrun <= 1'b0;
                r_ack_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (run_i) r_state <= S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (!run_i) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (busy_i) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_start <= 1'b1;
                            r_color <= r_pat;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state   <= S_ACK;
                    r_ack_cnt <= '0;
                end
                S_ACK: begin
                    if (busy_i) begin
                        r_state <= S_DONE;
                    end else if (r_ack_cnt == ACK_LAST) begin
                        r_ack_err <= 1'b1;
                        r_state   <= S_WAIT_TICK;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!busy_i) begin
                        r_state     <= S_FIN;
                        r_en        <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        if (r_rot_cnt == ROT_LAST) begin
                            r_pat     <= {r_pat[PW-ZW-1:0], r_pat[PW-1:PW-ZW]};
                            r_rot_cnt <= '0;
                        end else begin
                            r_rot_cnt <= r_rot_cnt + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= run_i ? S_WAIT_TICK : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // A host load overrides any rotation landing on the same edge.
            if (load_i) begin
                r_pat     <= pattern_i;
                r_rot_cnt <= '0;
            end
        end
    end

    assign start_o     = r_start;
    assign en_o        = r_en;
    assign color_o     = r_color;
    assign frame_cnt_o = r_frame_cnt;
    assign overrun_o   = r_overrun;
    assign ack_err_o   = r_ack_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: event-time reference model (tick phase arithmetic, zone array
// rotation) checked every cycle, with randomised busy lengths and load patterns.
module tb_led_frame_sched;

    localparam int FP = 8;
    localparam int RF = 2;
    localparam int AT = 16;
    localparam int NZ = 8;
    localparam logic [95:0] PAT_RST = 96'hfff_f0f_00f_0ff_0f0_ff0_fa0_f00;

    logic        clk_fast = 1'b0;
    logic        rstn = 1'b0;
    logic        run_i = 1'b0;
    logic        busy_i = 1'b0;
    logic        load_i = 1'b0;
    logic [95:0] pattern_i = '0;
    logic        clr_i = 1'b0;
    logic        start_o;
    logic        en_o;
    logic [95:0] color_o;
    logic [15:0] frame_cnt_o;
    logic        overrun_o;
    logic        ack_err_o;
    logic [2:0]  dbg_state_o;

    led_frame_sched #(
        .ZONES(NZ), .CW(4), .FRAME_PERIOD(FP), .ROTATE_FRAMES(RF),
        .ACK_TIMEOUT(AT), .PAT_RST(PAT_RST)
    ) dut (
        .clk_fast(clk_fast), .rstn(rstn), .run_i(run_i), .busy_i(busy_i),
        .load_i(load_i), .pattern_i(pattern_i), .clr_i(clr_i),
        .start_o(start_o), .en_o(en_o), .color_o(color_o),
        .frame_cnt_o(frame_cnt_o), .overrun_o(overrun_o), .ack_err_o(ack_err_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_fast = ~clk_fast;

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    // Reference model: zone array, counters, and the cycles at which events are due.
    logic [11:0] m_zone [NZ];
    int          m_rot;
    logic [95:0] m_color;
    logic [15:0] m_cnt;
    bit          m_ovr;
    bit          m_ack;
    int          m_phase = 0;
    int          m_start_cyc = -1;
    int          m_en_cyc = -1;
    int          m_ovr_cyc = -1;
    int          m_ack_cyc = -1;

    function automatic logic [95:0] m_flat();
        logic [95:0] f;
        for (int i = 0; i < NZ; i++) f[i*12 +: 12] = m_zone[i];
        return f;
    endfunction

    task automatic m_load(input logic [95:0] p);
        for (int i = 0; i < NZ; i++) m_zone[i] = p[i*12 +: 12];
        m_rot = 0;
    endtask

    task automatic m_reset();
        m_load(PAT_RST);
        m_color = '0;
        m_cnt = '0;
        m_ovr = 1'b0;
        m_ack = 1'b0;
        m_start_cyc = -1;
        m_en_cyc = -1;
        m_ovr_cyc = -1;
        m_ack_cyc = -1;
    endtask

    // First tick-aligned start cycle not earlier than t_min.
    function automatic int align(input int t_min);
        int k;
        k = (t_min - m_phase + FP - 1) / FP;
        return m_phase + k * FP;
    endfunction

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          s_rst, s_load, s_clr;
        logic [95:0] s_pat;
        logic [11:0] top;
        s_rst  = !rstn;
        s_load = load_i;
        s_clr  = clr_i;
        s_pat  = pattern_i;
        @(posedge clk_fast);
        #1;
        cyc++;
        if (s_rst) begin
            m_reset();
        end else begin
            if (cyc == m_start_cyc) m_color = m_flat();
            if (cyc == m_en_cyc) begin
                m_cnt++;
                m_rot++;
                if (m_rot == RF) begin
                    top = m_zone[NZ-1];
                    for (int i = NZ - 1; i > 0; i--) m_zone[i] = m_zone[i-1];
                    m_zone[0] = top;
                    m_rot = 0;
                end
            end
            if (s_load) m_load(s_pat);
            if (s_clr) begin
                m_ovr = 1'b0;
                m_ack = 1'b0;
            end
            if (cyc == m_ovr_cyc) m_ovr = 1'b1;
            if (cyc == m_ack_cyc) m_ack = 1'b1;
        end
        check("start_o", start_o, (cyc == m_start_cyc));
        check("en_o", en_o, (cyc == m_en_cyc));
        check("color_o", color_o, m_color);
        check("frame_cnt_o", frame_cnt_o, m_cnt);
        check("overrun_o", overrun_o, m_ovr);
        check("ack_err_o", ack_err_o, m_ack);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // One handshaked frame: busy is raised alongside start_o and held for blen cycles.
    task automatic do_frame(input int blen, input bit drop, input bit ld, input logic [95:0] lp);
        int s;
        run_to(m_start_cyc);
        s = cyc;
        busy_i = 1'b1;
        m_en_cyc = s + blen + 1;
        if (drop) begin
            run_to(s + 3);
            run_i = 1'b0;
        end
        run_to(s + blen);
        busy_i = 1'b0;
        if (ld) begin
            load_i = 1'b1;
            pattern_i = lp;
        end
        step();
        load_i = 1'b0;
        if (!drop) begin
            m_phase = s;
            m_start_cyc = align(m_en_cyc + 2);
        end
    endtask

    task automatic do_overrun(input bit with_clr);
        int t;
        t = m_start_cyc;
        busy_i = 1'b1;
        run_to(t - 1);
        if (with_clr) clr_i = 1'b1;
        m_ovr_cyc = t;
        m_phase = t;
        m_start_cyc = t + FP;
        step();
        busy_i = 1'b0;
        clr_i = 1'b0;
    endtask

    task automatic do_timeout();
        int s;
        run_to(m_start_cyc);
        s = cyc;
        m_ack_cyc = s + AT + 1;
        run_to(s + AT + 1);
        m_phase = s;
        m_start_cyc = align(s + AT + 2);
    endtask

    task automatic clr_pulse();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    task automatic begin_run();
        run_i = 1'b1;
        m_phase = cyc + FP;
        m_start_cyc = m_phase;
    endtask

    initial begin
        logic [95:0] rp;
        int          cnt_before;

        // Reset state
        repeat (3) step();
        check("reset color_o", color_o, 96'h0);
        check("reset frame_cnt_o", frame_cnt_o, 16'h0);

        // Periodic frames, busy high 5 cycles
        rstn = 1'b1;
        begin_run();
        do_frame(5, 1'b0, 1'b0, '0);
        check("frame_cnt 1", frame_cnt_o, 16'd1);
        do_frame(5, 1'b0, 1'b0, '0);
        check("frame_cnt 2", frame_cnt_o, 16'd2);
        run_to(m_start_cyc);
        check("rotated zone0", color_o[11:0], 12'hfff);
        check("rotated zone1", color_o[23:12], 12'hf00);
        do_frame(5, 1'b0, 1'b0, '0);
        check("frame_cnt 3", frame_cnt_o, 16'd3);

        // Random busy lengths, including ones that overrun the next tick slot
        for (int i = 0; i < 6; i++) do_frame($urandom_range(2, 7), 1'b0, 1'b0, '0);

        // Overrun, clear, and clear coinciding with a new overrun
        do_overrun(1'b0);
        check("overrun set", overrun_o, 1'b1);
        clr_pulse();
        check("overrun cleared", overrun_o, 1'b0);
        do_frame($urandom_range(2, 5), 1'b0, 1'b0, '0);
        do_overrun(1'b1);
        check("overrun set wins over clr", overrun_o, 1'b1);
        clr_pulse();

        // Ack timeout, then the next tick still issues a frame
        cnt_before = int'(frame_cnt_o);
        do_timeout();
        check("ack_err set", ack_err_o, 1'b1);
        check("frame_cnt after timeout", frame_cnt_o, 16'(cnt_before));
        do_frame($urandom_range(2, 5), 1'b0, 1'b0, '0);
        clr_pulse();

        // Load landing on a rotating frame's completion edge
        for (int i = 0; i < RF && m_rot != RF - 1; i++) do_frame(5, 1'b0, 1'b0, '0);
        do_frame(4, 1'b0, 1'b1, 96'h1);
        run_to(m_start_cyc);
        check("loaded pattern", color_o, 96'h1);
        do_frame(3, 1'b0, 1'b0, '0);

        // Random load while waiting for a tick
        rp = {$urandom, $urandom, $urandom};
        load_i = 1'b1;
        pattern_i = rp;
        step();
        load_i = 1'b0;
        run_to(m_start_cyc);
        check("random load colour", color_o, rp);
        do_frame($urandom_range(2, 5), 1'b0, 1'b0, '0);

        // run_i dropped mid-frame: frame completes, then no further starts
        do_frame(5, 1'b1, 1'b0, '0);
        repeat (3 * FP) step();
        begin_run();
        do_frame($urandom_range(2, 5), 1'b0, 1'b0, '0);

        // Reset in the middle of the ack wait
        run_to(m_start_cyc);
        run_to(cyc + 2);
        rstn = 1'b0;
        step();
        check("mid-ACK reset start_o", start_o, 1'b0);
        check("mid-ACK reset color_o", color_o, 96'h0);
        check("mid-ACK reset frame_cnt_o", frame_cnt_o, 16'h0);
        step();
        rstn = 1'b1;
        begin_run();
        do_frame(5, 1'b0, 1'b0, '0);
        check("frame_cnt after reset", frame_cnt_o, 16'd1);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
